// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the
// button/switch input front end.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } chan_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 5000000;
  localparam logic [3:0] DEF_REPEAT_MASK = 4'b0110;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: synchroniser, debounce
// FSM, hold/repeat counter and edge pulses.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter logic INVERT = 1'b1,
  parameter logic SYNC_RST = 1'b1,
  parameter logic REPEAT_EN = 1'b0,
  parameter int DEB_CYC = DEF_DEBOUNCE_CYCLES,
  parameter int RPT_DLY = DEF_REPEAT_DELAY_CYCLES,
  parameter int RPT_PER = DEF_REPEAT_PERIOD_CYCLES,
  parameter int CW = cnt_width(DEB_CYC, RPT_DLY, RPT_PER)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CW-1:0] DEB_T = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] DLY_T = CW'(RPT_DLY - 1);
  localparam logic [CW-1:0] PER_T = CW'(RPT_PER - 1);

  logic [1:0] sync;
  logic s;
  chan_state_t state;
  logic [CW-1:0] cnt;

  // two-flop synchroniser, parked at the idle pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {2{SYNC_RST}};
    else sync <= {sync[0], raw};
  end

  assign s = sync[1] ^ INVERT;

  // debounce both edges, time the hold, emit registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      press <= 1'b0;
      rel <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_DB;
            cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!s) begin
            state <= IDLE;
            cnt <= '0;
          end else if (cnt == DEB_T) begin
            state <= HELD;
            cnt <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_DB;
            cnt <= '0;
          end else if (REPEAT_EN) begin
            if (cnt == DLY_T) begin
              state <= REPEAT;
              cnt <= '0;
              press <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        REPEAT: begin
          if (!s) begin
            state <= RELEASE_DB;
            cnt <= '0;
          end else if (cnt == PER_T) begin
            cnt <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE_DB: begin
          if (s) begin
            state <= HELD;
            cnt <= '0;
          end else if (cnt == DEB_T) begin
            state <= IDLE;
            cnt <= '0;
            level <= 1'b0;
            rel <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Board input front end: debounced push-buttons
// with repeat and sticky flags, plus slide switch.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter logic [N_BTN-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_n_raw,
  input  logic             switch_raw,
  input  logic [N_BTN-1:0] press_clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] press_flag,
  output logic             switch_level,
  output logic             switch_change
);

  localparam int CW = cnt_width(
    DEBOUNCE_CYCLES,
    REPEAT_DELAY_CYCLES,
    REPEAT_PERIOD_CYCLES
  );

  logic sw_rise;
  logic sw_fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_channel #(
      .INVERT   (1'b1),
      .SYNC_RST (1'b1),
      .REPEAT_EN(REPEAT_MASK[i]),
      .DEB_CYC  (DEBOUNCE_CYCLES),
      .RPT_DLY  (REPEAT_DELAY_CYCLES),
      .RPT_PER  (REPEAT_PERIOD_CYCLES),
      .CW       (CW)
    ) u_ch (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .raw  (btn_n_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  button_channel #(
    .INVERT   (1'b0),
    .SYNC_RST (1'b0),
    .REPEAT_EN(1'b0),
    .DEB_CYC  (DEBOUNCE_CYCLES),
    .RPT_DLY  (REPEAT_DELAY_CYCLES),
    .RPT_PER  (REPEAT_PERIOD_CYCLES),
    .CW       (CW)
  ) u_sw (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .raw  (switch_raw),
    .level(switch_level),
    .press(sw_rise),
    .rel  (sw_fall)
  );

  // both sources are flops and never high together
  assign switch_change = sw_rise | sw_fall;

  // sticky flags: a press in the same cycle as a clear wins
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) press_flag <= '0;
    else press_flag <= btn_press | (press_flag & ~press_clr);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for
// button_conditioner with a run-length model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam bit [3:0] MASK = 4'b0110;

  logic clk;
  logic rst;
  logic [3:0] btn_n_raw;
  logic switch_raw;
  logic [3:0] press_clr;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] press_flag;
  logic switch_level;
  logic switch_change;

  button_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_PERIOD_CYCLES(RP),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .btn_n_raw(btn_n_raw),
    .switch_raw(switch_raw),
    .press_clr(press_clr),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .press_flag(press_flag),
    .switch_level(switch_level),
    .switch_change(switch_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: per channel, samples seen two edges late,
  // a streak of samples disagreeing with the level,
  // and the age of an uninterrupted hold.
  bit h0 [5];
  bit h1 [5];
  bit lvl [5];
  int streak [5];
  int age [5];
  bit mp [5];
  bit mr [5];
  bit [3:0] mflag;

  task automatic m_reset();
    for (int c = 0; c < 5; c++) begin
      h0[c] = 0; h1[c] = 0; lvl[c] = 0;
      streak[c] = 0; age[c] = 0;
      mp[c] = 0; mr[c] = 0;
    end
    mflag = '0;
  endtask

  task automatic m_step();
    bit s;
    bit re;
    for (int i = 0; i < 4; i++)
      mflag[i] = mp[i] | (mflag[i] & ~press_clr[i]);
    for (int c = 0; c < 5; c++) begin
      s = h1[c];
      h1[c] = h0[c];
      if (c < 4) h0[c] = ~btn_n_raw[c];
      else h0[c] = switch_raw;
      re = (c < 4) ? MASK[c] : 1'b0;
      mp[c] = 0;
      mr[c] = 0;
      if (s != lvl[c]) begin
        streak[c]++;
        if (streak[c] == D + 1) begin
          lvl[c] = s;
          if (s) mp[c] = 1; else mr[c] = 1;
          streak[c] = 0;
          age[c] = 0;
        end
      end else begin
        if (lvl[c] && streak[c] > 0) age[c] = 0;
        else if (lvl[c]) age[c]++;
        streak[c] = 0;
        if (lvl[c] && re && age[c] >= RD &&
            (age[c] - RD) % RP == 0)
          mp[c] = 1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        logic [3:0] el, ep, er;
        for (int i = 0; i < 4; i++) begin
          el[i] = lvl[i]; ep[i] = mp[i]; er[i] = mr[i];
        end
        chk("btn_level", btn_level, el);
        chk("btn_press", btn_press, ep);
        chk("btn_release", btn_release, er);
        chk("press_flag", press_flag, mflag);
        chk("switch_level", switch_level, lvl[4]);
        chk("switch_change", switch_change,
            mp[4] | mr[4]);
      end
    end
  end

  int pa[$];
  int ra[$];
  bit lv [0:127];
  bit fl [0:127];
  logic [3:0] clr_plan [0:127];

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // pin low from edge 0 to edge hold, record ncyc edges
  task automatic btn_run(input int ch, input int hold,
                         input int ncyc);
    pa.delete();
    ra.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) btn_n_raw[ch] = 1'b0;
      if (c == hold) btn_n_raw[ch] = 1'b1;
      press_clr = clr_plan[c];
      @(posedge clk);
      @(negedge clk);
      if (btn_press[ch]) pa.push_back(c);
      if (btn_release[ch]) ra.push_back(c);
      lv[c] = btn_level[ch];
      fl[c] = press_flag[ch];
      #2;
    end
    press_clr = '0;
  endtask

  int rem [5];
  bit cur [5];
  bit any;
  int exp_rep [6];

  initial begin
    rst = 1'b1;
    btn_n_raw = 4'hF;
    switch_raw = 1'b0;
    press_clr = '0;
    for (int c = 0; c < 128; c++) clr_plan[c] = '0;
    @(posedge clk);
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset level", btn_level, 0);
    chk("reset flag", press_flag, 0);
    chk("reset sw", {switch_level, switch_change}, 0);
    #2 rst = 1'b0;
    idle(10);

    // clean press on button 0
    btn_run(0, 30, 45);
    chk("t1 press count", pa.size(), 1);
    chk("t1 press edge", qat(pa, 0), 6);
    chk("t1 level@5", lv[5], 0);
    chk("t1 level@6", lv[6], 1);
    chk("t1 level@35", lv[35], 1);
    chk("t1 level@36", lv[36], 0);
    chk("t1 release count", ra.size(), 1);
    chk("t1 release edge", qat(ra, 0), 36);
    idle(5);

    // 3-cycle glitch
    btn_run(0, 3, 20);
    any = 0;
    for (int c = 0; c < 20; c++) any |= lv[c];
    chk("glitch press", pa.size(), 0);
    chk("glitch release", ra.size(), 0);
    chk("glitch level", any, 0);
    idle(5);

    // auto-repeat on button 1
    exp_rep = '{6, 26, 34, 42, 50, 58};
    btn_run(1, 60, 75);
    chk("rep count", pa.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("rep edge", qat(pa, k), exp_rep[k]);
    chk("rep release", qat(ra, 0), 66);
    idle(5);

    // sticky flag on button 2
    clr_plan[22] = 4'b0100;
    clr_plan[27] = 4'b0100;
    clr_plan[30] = 4'b0100;
    clr_plan[31] = 4'b0100;
    btn_run(2, 40, 55);
    for (int c = 0; c < 128; c++) clr_plan[c] = '0;
    chk("flag@7", fl[7], 1);
    chk("flag@21", fl[21], 1);
    chk("flag clr@22", fl[22], 0);
    chk("flag@26", fl[26], 0);
    chk("flag set wins@27", fl[27], 1);
    chk("flag clr@30", fl[30], 0);
    chk("flag idle clr@31", fl[31], 0);
    chk("flag@35", fl[35], 1);
    idle(5);

    // reset while button 3 is held
    btn_n_raw[3] = 1'b0;
    idle(12);
    chk("pre-rst level3", btn_level[3], 1);
    chk("pre-rst flag3", press_flag[3], 1);
    rst = 1'b1;
    #1;
    chk("rst async level", btn_level, 0);
    chk("rst async flag", press_flag, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    pa.delete();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (btn_press[3]) pa.push_back(c);
      #2;
    end
    chk("post-rst press count", pa.size(), 1);
    chk("post-rst press edge", qat(pa, 0), 6);
    btn_n_raw[3] = 1'b1;
    idle(12);

    // switch with a short bounce
    pa.delete();
    for (int c = 0; c < 40; c++) begin
      if (c == 0) switch_raw = 1'b1;
      if (c == 20) switch_raw = 1'b0;
      if (c == 22) switch_raw = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (switch_change) pa.push_back(c);
      lv[c] = switch_level;
      #2;
    end
    chk("sw change count", pa.size(), 1);
    chk("sw change edge", qat(pa, 0), 6);
    chk("sw level@5", lv[5], 0);
    chk("sw level@6", lv[6], 1);
    chk("sw level@39", lv[39], 1);
    switch_raw = 1'b0;
    idle(12);

    // random phase
    for (int c = 0; c < 5; c++) begin
      cur[c] = 0;
      rem[c] = $urandom_range(1, 20);
    end
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (rem[c] == 0) begin
          cur[c] = ~cur[c];
          if ($urandom % 4 == 0)
            rem[c] = $urandom_range(1, 4);
          else
            rem[c] = $urandom_range(5, 60);
        end else begin
          rem[c]--;
        end
      end
      for (int c = 0; c < 4; c++) begin
        btn_n_raw[c] = ~cur[c];
        press_clr[c] = ($urandom % 6 == 0);
      end
      switch_raw = cur[4];
      if (k == 2000) rst = 1'b1;
      if (k == 2002) rst = 1'b0;
      @(negedge clk);
      #2;
    end
    btn_n_raw = 4'hF;
    switch_raw = 1'b0;
    press_clr = '0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
